// File: rtl/gcd_pkg.sv
//------------------------------------------------------------------------------
// Module : gcd_pkg
// Brief  : Shared types and defaults for the GCD arbiter slice.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gcd_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        DROP_A = 3'd2,
        SEND_B = 3'd3,
        DROP_B = 3'd4,
        RESP   = 3'd5
    } gcd_arb_state_t;

    // States in which the GCD handshake request is held high.
    function automatic logic is_send(input gcd_arb_state_t s);
        return (s == SEND_A) || (s == SEND_B);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : One-hot round-robin arbiter; pointer moves past the winner on advance.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic           advance_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_idx_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Scan from the pointer upward, wrapping at N, first requester wins.
    always_comb begin
        logic           found;
        int             j;
        logic [IDW-1:0] idx;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        j           = 0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = IDW'(j);
            if (!found && req_i[idx]) begin
                found            = 1'b1;
                grant_o[idx]     = 1'b1;
                grant_idx_o      = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (|req_i)) begin
            ptr_d = (grant_idx_o == IDW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_arbiter.sv
//------------------------------------------------------------------------------
// Module : gcd_arbiter
// Brief  : Shares one 4-phase GCD unit among N valid/ready requesters.
//          Optional GCD_ARB_ZERO_BYPASS_EN answers zero-operand pairs directly.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter  int N   = DEFAULT_N,
    parameter  int W   = DEFAULT_W,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_valid_i,
    output logic [N-1:0]   req_ready_o,
    input  logic [N*W-1:0] req_a_i,
    input  logic [N*W-1:0] req_b_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [IDW-1:0] rsp_id_o,
    output logic [W-1:0]   rsp_data_o,
    output logic           gcd_req_o,
    input  logic           gcd_ack_i,
    output logic [W-1:0]   gcd_load_val_o,
    input  logic [W-1:0]   gcd_result_i
);

    gcd_arb_state_t state_q, state_d;

    logic [W-1:0]   b_q, b_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   load_q, load_d;
    logic           valid_q, valid_d;
    logic           gcdreq_q, gcdreq_d;

    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic           in_idle;
    logic           take;
    logic [W-1:0]   win_a;
    logic [W-1:0]   win_b;
    logic           win_zero;

    assign in_idle = (state_q == IDLE);
    assign take    = in_idle && (|req_valid_i);
    assign win_a   = req_a_i[int'(grant_idx)*W +: W];
    assign win_b   = req_b_i[int'(grant_idx)*W +: W];

`ifdef GCD_ARB_ZERO_BYPASS_EN
    assign win_zero = (win_a == '0) || (win_b == '0);
`else
    assign win_zero = 1'b0;
`endif

    rr_arbiter #(
        .N (N)
    ) u_rr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_valid_i),
        .advance_i   (in_idle),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Acceptance is the only combinational output and exists only in IDLE.
    assign req_ready_o = in_idle ? grant : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take)         state_d = win_zero ? RESP : SEND_A;
            SEND_A:  if (gcd_ack_i)    state_d = DROP_A;
            DROP_A:  if (!gcd_ack_i)   state_d = SEND_B;
            SEND_B:  if (gcd_ack_i)    state_d = DROP_B;
            DROP_B:  if (!gcd_ack_i)   state_d = RESP;
            RESP:    if (rsp_ready_i)  state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        b_d      = b_q;
        id_d     = id_q;
        data_d   = data_q;
        load_d   = load_q;
        if (take) begin
            b_d    = win_b;
            id_d   = grant_idx;
            load_d = win_a;
            if (win_zero) begin
                data_d = win_a | win_b;
            end
        end
        // b goes on the bus as soon as DROP_A is entered, ahead of the second req.
        if ((state_q == SEND_A) && (state_d == DROP_A)) begin
            load_d = b_q;
        end
        if ((state_q == SEND_B) && gcd_ack_i) begin
            data_d = gcd_result_i;
        end
        valid_d  = (state_d == RESP);
        gcdreq_d = is_send(state_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_q      <= '0;
            id_q     <= '0;
            data_q   <= '0;
            load_q   <= '0;
            valid_q  <= 1'b0;
            gcdreq_q <= 1'b0;
        end else begin
            b_q      <= b_d;
            id_q     <= id_d;
            data_q   <= data_d;
            load_q   <= load_d;
            valid_q  <= valid_d;
            gcdreq_q <= gcdreq_d;
        end
    end

    assign rsp_valid_o    = valid_q;
    assign rsp_id_o       = id_q;
    assign rsp_data_o     = data_q;
    assign gcd_req_o      = gcdreq_q;
    assign gcd_load_val_o = load_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_gcd_arbiter
// Brief  : Self-checking bench for gcd_arbiter with a behavioural 4-phase GCD.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_gcd_arbiter;

    localparam int N   = 4;
    localparam int W   = 128;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           gcd_req;
    logic           gcd_ack;
    logic [W-1:0]   gcd_load_val;
    logic [W-1:0]   gcd_result;

    always #5 clk = ~clk;

    gcd_arbiter #(.N(N), .W(W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_a_i        (req_a),
        .req_b_i        (req_b),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_id_o       (rsp_id),
        .rsp_data_o     (rsp_data),
        .gcd_req_o      (gcd_req),
        .gcd_ack_i      (gcd_ack),
        .gcd_load_val_o (gcd_load_val),
        .gcd_result_i   (gcd_result)
    );

    // Behavioural GCD: first req latches a, second req latches b and answers after a delay.
    logic [W-1:0] m_a;
    logic         m_phase;
    int           m_wait;

    function automatic logic [W-1:0] euclid(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gcd_ack    <= 1'b0;
            gcd_result <= '0;
            m_a        <= '0;
            m_phase    <= 1'b0;
            m_wait     <= 0;
        end else if (gcd_req && !gcd_ack) begin
            if (!m_phase) begin
                m_a     <= gcd_load_val;
                gcd_ack <= 1'b1;
                m_phase <= 1'b1;
            end else if (m_wait < 3) begin
                m_wait <= m_wait + 1;
            end else begin
                gcd_result <= euclid(m_a, gcd_load_val);
                gcd_ack    <= 1'b1;
                m_phase    <= 1'b0;
                m_wait     <= 0;
            end
        end else if (!gcd_req && gcd_ack) begin
            gcd_ack <= 1'b0;
        end
    end

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } rsp_t;

    vec_t         tab [16];
    rsp_t         sb [$];
    int           grant_log [$];
    int           exp_grants [$];
    logic [W-1:0] pend_exp [N];
    logic [N-1:0] granted_now = '0;

    int n_vec   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int gcd_rises   = 0;
    int grant_cyc   = 0;
    int rsp_rise_cyc = 0;
    logic gcd_prev = 1'b0;
    logic rsp_prev = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        rsp_t e;
        cyc++;
        granted_now = '0;
        check("ready_onehot", {127'b0, $onehot0(req_ready)}, 1);
        check("ready_subset_valid", {124'b0, req_ready & ~req_valid}, 0);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                e.id   = IDW'(i);
                e.data = pend_exp[i];
                sb.push_back(e);
                grant_log.push_back(i);
                grant_cyc      = cyc;
                granted_now[i] = 1'b1;
            end
        end
`ifndef GCD_ARB_ZERO_BYPASS_EN
        for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
                assert (req_a[i*W +: W] != '0 && req_b[i*W +: W] != '0)
                    else $error("zero operand driven on requester %0d", i);
            end
        end
`endif
        if (gcd_req && !gcd_prev) gcd_rises++;
        gcd_prev = gcd_req;
        if (rsp_valid) begin
            if (!rsp_prev) rsp_rise_cyc = cyc;
            check("resp_no_ready", {124'b0, req_ready}, 0);
            check("resp_no_gcd_req", {127'b0, gcd_req}, 0);
            if (rsp_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id %0d data %0h, expected none", rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", {126'b0, rsp_id}, {126'b0, e.id});
                    check("rsp_data", rsp_data, e.data);
                end
            end
        end
        rsp_prev = rsp_valid;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~granted_now;
    endtask

    task automatic submit(input int k);
        int i;
        i = tab[k].id;
        req_a[i*W +: W] = tab[k].a;
        req_b[i*W +: W] = tab[k].b;
        pend_exp[i]     = tab[k].exp;
        req_valid[i]    = 1'b1;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((req_valid != '0 || sb.size() != 0) && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic check_grants(input string name);
        check({name, "_count"}, W'(grant_log.size()), W'(exp_grants.size()));
        for (int i = 0; i < exp_grants.size() && i < grant_log.size(); i++) begin
            check(name, W'(grant_log[i]), W'(exp_grants[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        gcd_prev = 1'b0;
        rsp_prev = 1'b0;
    endtask

    initial begin
        int g0;
        int c;
        logic [W-1:0] big;
        big      = '0;
        big[127] = 1'b1;

        tab[0]  = '{0, 48, 18, 6};
        tab[1]  = '{0, 12, 8, 4};
        tab[2]  = '{1, 35, 14, 7};
        tab[3]  = '{2, 9, 27, 9};
        tab[4]  = '{3, 17, 5, 1};
        tab[5]  = '{1, 35, 14, 7};
        tab[6]  = '{3, 17, 5, 1};
        tab[7]  = '{2, 48, 18, 6};
        tab[8]  = '{0, 100, 75, 25};
        tab[9]  = '{1, 7, 7, 7};
        tab[10] = '{0, 9, 27, 9};
        tab[11] = '{2, 1, big, 1};
        tab[12] = '{3, 17, 5, 1};
        tab[13] = '{0, 12, 8, 4};
        tab[14] = '{1, 0, 42, 42};
        tab[15] = '{2, 0, 0, 0};
        for (int i = 0; i < N; i++) pend_exp[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {124'b0, req_ready}, 0);
        check("rst_rsp_valid", {127'b0, rsp_valid}, 0);
        check("rst_rsp_id", {126'b0, rsp_id}, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_gcd_req", {127'b0, gcd_req}, 0);
        check("rst_gcd_load_val", gcd_load_val, 0);
        rst = 1'b0;

        // Single job
        g0 = gcd_rises;
        submit(0);
        drain(200);
        check("single_gcd_req_rises", W'(gcd_rises - g0), 2);
        exp_grants = '{0};
        check_grants("single_grant");

        // Contention from a freshly reset pointer
        do_reset();
        grant_log.delete();
        for (int k = 1; k <= 4; k++) submit(k);
        drain(800);
        exp_grants = '{0, 1, 2, 3};
        check_grants("contention_grant");

        // Backpressure with another requester waiting
        grant_log.delete();
        rsp_ready = 1'b0;
        submit(5);
        submit(6);
        c = 0;
        while (!rsp_valid && c < 200) begin
            step();
            c++;
        end
        check("bp_rsp_seen", {127'b0, rsp_valid}, 1);
        for (int t = 0; t < 20; t++) begin
            step();
            check("bp_valid_held", {127'b0, rsp_valid}, 1);
            check("bp_id_stable", {126'b0, rsp_id}, 1);
            check("bp_data_stable", rsp_data, 7);
        end
        rsp_ready = 1'b1;
        drain(400);
        exp_grants = '{1, 3};
        check_grants("bp_grant");

        // Reset while the second operand is being offered
        submit(7);
        c = 0;
        while (!(gcd_req && gcd_load_val == 18) && c < 100) begin
            step();
            c++;
        end
        check("midjob_in_send_b", {127'b0, gcd_req}, 1);
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", {124'b0, req_ready}, 0);
        check("midrst_rsp_valid", {127'b0, rsp_valid}, 0);
        check("midrst_rsp_id", {126'b0, rsp_id}, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_gcd_req", {127'b0, gcd_req}, 0);
        check("midrst_gcd_load_val", gcd_load_val, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        gcd_prev = 1'b0;
        rsp_prev = 1'b0;
        grant_log.delete();
        submit(8);
        drain(200);

        // Equal operands, ones, and pointer position after each
        submit(9);
        submit(10);
        drain(400);
        submit(11);
        drain(200);
        submit(12);
        submit(13);
        drain(400);
        exp_grants = '{0, 1, 0, 2, 3, 0};
        check_grants("rr_grant");

`ifdef GCD_ARB_ZERO_BYPASS_EN
        g0 = gcd_rises;
        submit(14);
        drain(100);
        check("bypass_latency_0_42", W'(rsp_rise_cyc - grant_cyc), 1);
        submit(15);
        drain(100);
        check("bypass_latency_0_0", W'(rsp_rise_cyc - grant_cyc), 1);
        check("bypass_no_gcd_req", W'(gcd_rises - g0), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
